// File: rtl/vpu_pkg.sv
// Shared VPU types: host request instruction, dispatcher queue entry,
// stream-ID pool sizing and a lowest-free-ID priority encoder.
package vpu_pkg;

  localparam int STREAM_ID_WIDTH = 2;
  localparam int NUM_ID = 2 ** STREAM_ID_WIDTH;
  localparam int VPU_TAG_W = 8;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [5:0]  dst0;
    logic [5:0]  src0;
    logic [5:0]  src1;
    logic [5:0]  src2;
    logic [15:0] imm;
  } vpu_h2d_req_instr_t;

  typedef struct packed {
    vpu_h2d_req_instr_t     instr;
    logic [VPU_TAG_W-1:0]   tag;
  } vpu_cmd_entry_t;

  function automatic logic [STREAM_ID_WIDTH-1:0] lowest_zero(
    input logic [NUM_ID-1:0] v
  );
    logic [STREAM_ID_WIDTH-1:0] r;
    r = '0;
    for (int i = NUM_ID - 1; i >= 0; i--) begin
      if (!v[i]) r = STREAM_ID_WIDTH'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/vpu_cmd_fifo.sv
// Synchronous instruction FIFO with occupancy count.
// A push while full is ignored even if a pop happens that cycle.
module vpu_cmd_fifo
  import vpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  vpu_cmd_entry_t         data_i,
  input  logic                   pop_i,
  output vpu_cmd_entry_t         data_o,
  output logic [$clog2(DEPTH):0] cnt_o,
  output logic                   full_o
);

  localparam int PW = $clog2(DEPTH);

  vpu_cmd_entry_t mem_q [DEPTH];
  logic [PW-1:0]  wr_q;
  logic [PW-1:0]  rd_q;
  logic [PW:0]    cnt_q;
  logic           do_push;
  logic           do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & (cnt_q != '0);
  assign data_o  = mem_q[rd_q];
  assign cnt_o   = cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/vpu_cmd_dispatcher.sv
// Host-side dispatcher: queues instructions, hands each a free stream ID
// at issue and turns VPU responses back into host-tagged completions.
module vpu_cmd_dispatcher
  import vpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_WIDTH  = VPU_TAG_W
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cmd_valid_i,
  output logic                                cmd_ready_o,
  input  logic [$bits(vpu_h2d_req_instr_t)-1:0] cmd_instr_i,
  input  logic [TAG_WIDTH-1:0]                cmd_tag_i,
  output logic                                vpu_valid_o,
  input  logic                                vpu_ready_i,
  output logic [$bits(vpu_h2d_req_instr_t)-1:0] vpu_instr_o,
  output logic [STREAM_ID_WIDTH-1:0]          vpu_stream_id_o,
  input  logic                                rsp_valid_i,
  input  logic [STREAM_ID_WIDTH-1:0]          rsp_stream_id_i,
  output logic                                rsp_ready_o,
  output logic                                cpl_valid_o,
  output logic [TAG_WIDTH-1:0]                cpl_tag_o,
  input  logic                                cpl_ready_i,
  output logic [STREAM_ID_WIDTH:0]            inflight_cnt_o,
  output logic                                idle_o,
  output logic                                err_rsp_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = STREAM_ID_WIDTH + 1;

  vpu_cmd_entry_t push_data;
  vpu_cmd_entry_t head;
  logic [CW-1:0]  fifo_cnt;
  logic           fifo_full;
  logic           fifo_empty;

  logic [NUM_ID-1:0]          busy_q;
  logic [NUM_ID-1:0]          busy_d;
  logic [TAG_WIDTH-1:0]       tag_tbl_q [NUM_ID];
  logic                       cpl_valid_q;
  logic                       cpl_valid_d;
  logic [TAG_WIDTH-1:0]       cpl_tag_q;
  logic [TAG_WIDTH-1:0]       cpl_tag_d;
  logic [IW-1:0]              inflight_q;
  logic [IW-1:0]              inflight_d;
  logic                       err_q;
  logic                       err_d;

  logic [STREAM_ID_WIDTH-1:0] alloc_id;
  logic                       any_free;
  logic                       push;
  logic                       issue;
  logic                       rsp_hs;
  logic                       rsp_hit;

  assign push_data.instr = cmd_instr_i;
  assign push_data.tag   = cmd_tag_i;

  vpu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .data_i (push_data),
    .pop_i  (issue),
    .data_o (head),
    .cnt_o  (fifo_cnt),
    .full_o (fifo_full)
  );

  assign fifo_empty = (fifo_cnt == '0);

  // alloc_id only ever moves down while a request waits, so the VPU
  // always sees a currently-free ID at the handshake.
  assign any_free = ~&busy_q;
  assign alloc_id = lowest_zero(busy_q);

  assign cmd_ready_o     = rst_n & ~fifo_full;
  assign vpu_valid_o     = rst_n & ~fifo_empty & any_free;
  assign vpu_instr_o     = head.instr;
  assign vpu_stream_id_o = alloc_id;
  assign rsp_ready_o     = rst_n & (~cpl_valid_q | cpl_ready_i);

  assign push    = cmd_valid_i & cmd_ready_o;
  assign issue   = vpu_valid_o & vpu_ready_i;
  assign rsp_hs  = rsp_valid_i & rsp_ready_o;
  assign rsp_hit = rsp_hs & busy_q[rsp_stream_id_i];

  always_comb begin
    busy_d      = busy_q;
    cpl_valid_d = cpl_valid_q;
    cpl_tag_d   = cpl_tag_q;
    err_d       = err_q;
    if (cpl_valid_q && cpl_ready_i) cpl_valid_d = 1'b0;
    if (rsp_hit) begin
      busy_d[rsp_stream_id_i] = 1'b0;
      cpl_valid_d             = 1'b1;
      cpl_tag_d               = tag_tbl_q[rsp_stream_id_i];
    end
    if (rsp_hs && !rsp_hit) err_d = 1'b1;
    if (issue) busy_d[alloc_id] = 1'b1;
    inflight_d = inflight_q + IW'(issue) - IW'(rsp_hit);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q      <= '0;
      cpl_valid_q <= 1'b0;
      cpl_tag_q   <= '0;
      inflight_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      cpl_valid_q <= cpl_valid_d;
      cpl_tag_q   <= cpl_tag_d;
      inflight_q  <= inflight_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) tag_tbl_q[alloc_id] <= head.tag;
  end

  assign cpl_valid_o    = cpl_valid_q;
  assign cpl_tag_o      = cpl_tag_q;
  assign inflight_cnt_o = inflight_q;
  assign err_rsp_o      = err_q;
  assign idle_o         = fifo_empty & (busy_q == '0) & ~cpl_valid_q;

endmodule
